asic_config_sequencer: RTL and testbench

- Controller in front of the ASIC bridge write path. Accepts static (88-bit) and dynamic (16-bit) configuration requests and arbitrates between them.
- Presents the selected word and its flag to the bridge, pulses start_ASIC_config, and waits for end_config.
- Checks the loopback XOR error outputs and retries on mismatch or timeout. Reports busy/done/error status to the system controller.

---
 rtl/asic_config_sequencer.sv | 195 +++++++++++++++++++
 tb/tb_asic_config_sequencer.sv | 302 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/asic_config_sequencer.sv
// Configuration write sequencer in front of the ASIC bridge: arbitrates static/dynamic
// requests, launches the bridge write, verifies the loopback and retries on mismatch or timeout.
module asic_config_sequencer #(
    parameter int unsigned SIZESRSTAT     = 88,
    parameter int unsigned SIZESRDYN      = 16,
    parameter int unsigned TIMEOUT_CYCLES = 4096,
    parameter int unsigned SETTLE_CYCLES  = 16,
    parameter int unsigned MAX_RETRIES    = 3
) (
    input  logic                  CLK,
    input  logic                  RST_N,
    input  logic                  req_stat,
    input  logic                  req_dyn,
    input  logic [SIZESRSTAT-1:0] stat_data_in,
    input  logic [SIZESRDYN-1:0]  dyn_data_in,
    input  logic                  end_config,
    input  logic                  xor_out_stat,
    input  logic                  xor_out_dyn,
    output logic [SIZESRSTAT-1:0] static_conf_ear,
    output logic [SIZESRDYN-1:0]  dynamic_conf,
    output logic                  flag_stat,
    output logic                  flag_dyn,
    output logic                  start_ASIC_config,
    output logic                  cfg_busy,
    output logic                  cfg_done,
    output logic                  cfg_err,
    output logic [1:0]            err_code,
    output logic [3:0]            retry_cnt
);

    localparam int unsigned CNT_MAX = (TIMEOUT_CYCLES > SETTLE_CYCLES) ? TIMEOUT_CYCLES : SETTLE_CYCLES;
    localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);
    localparam logic [1:0]  ERR_NONE     = 2'b00;
    localparam logic [1:0]  ERR_MISMATCH = 2'b01;
    localparam logic [1:0]  ERR_TIMEOUT  = 2'b10;

    typedef enum logic [3:0] {
        IDLE,
        LOAD,
        START,
        WAIT_END,
        SETTLE,
        CHECK,
        FAIL_CHK,
        DONE,
        ERR
    } state_t;

    state_t                 state;
    logic                   pending_stat;
    logic                   pending_dyn;
    logic [SIZESRSTAT-1:0]  shadow_stat;
    logic [SIZESRDYN-1:0]   shadow_dyn;
    logic [CNT_W-1:0]       cnt;
    logic                   end_prev;
    logic                   fail_timeout;

    logic end_rise;
    logic cnt_sat;
    logic timeout_hit;
    logic settle_hit;
    logic readback_bad;

    assign end_rise     = end_config & ~end_prev;
    assign cnt_sat      = (cnt == CNT_W'(CNT_MAX));
    assign timeout_hit  = (cnt >= CNT_W'(TIMEOUT_CYCLES - 1));
    assign settle_hit   = (cnt >= CNT_W'(SETTLE_CYCLES - 1));
    assign readback_bad = flag_stat ? xor_out_stat : xor_out_dyn;

    // Outputs are registered and take their value on entry to the state they belong to.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state             <= IDLE;
            pending_stat      <= 1'b0;
            pending_dyn       <= 1'b0;
            shadow_stat       <= '0;
            shadow_dyn        <= '0;
            cnt               <= '0;
            end_prev          <= 1'b0;
            fail_timeout      <= 1'b0;
            static_conf_ear   <= '0;
            dynamic_conf      <= '0;
            flag_stat         <= 1'b0;
            flag_dyn          <= 1'b0;
            start_ASIC_config <= 1'b0;
            cfg_busy          <= 1'b0;
            cfg_done          <= 1'b0;
            cfg_err           <= 1'b0;
            err_code          <= ERR_NONE;
            retry_cnt         <= 4'd0;
        end else begin
            end_prev          <= end_config;
            start_ASIC_config <= 1'b0;
            cfg_done          <= 1'b0;
            cfg_err           <= 1'b0;
            if (!cnt_sat) begin
                cnt <= cnt + CNT_W'(1);
            end

            // Request capture runs in every state; the in-flight word lives in the output regs.
            if (req_stat) begin
                pending_stat <= 1'b1;
                shadow_stat  <= stat_data_in;
            end
            if (req_dyn) begin
                pending_dyn <= 1'b1;
                shadow_dyn  <= dyn_data_in;
            end

            case (state)
                IDLE: begin
                    if (pending_stat) begin
                        pending_stat    <= 1'b0;
                        static_conf_ear <= req_stat ? stat_data_in : shadow_stat;
                        flag_stat       <= 1'b1;
                        flag_dyn        <= 1'b0;
                    end else if (pending_dyn) begin
                        pending_dyn  <= 1'b0;
                        dynamic_conf <= req_dyn ? dyn_data_in : shadow_dyn;
                        flag_stat    <= 1'b0;
                        flag_dyn     <= 1'b1;
                    end
                    if (pending_stat || pending_dyn) begin
                        state     <= LOAD;
                        cnt       <= '0;
                        cfg_busy  <= 1'b1;
                        retry_cnt <= 4'd0;
                        err_code  <= ERR_NONE;
                    end
                end
                LOAD: begin
                    state             <= START;
                    cnt               <= '0;
                    start_ASIC_config <= 1'b1;
                end
                START: begin
                    state <= WAIT_END;
                    cnt   <= '0;
                end
                WAIT_END: begin
                    if (end_rise) begin
                        state <= SETTLE;
                        cnt   <= '0;
                    end else if (timeout_hit) begin
                        state        <= FAIL_CHK;
                        cnt          <= '0;
                        fail_timeout <= 1'b1;
                    end
                end
                SETTLE: begin
                    if (settle_hit) begin
                        state <= CHECK;
                        cnt   <= '0;
                    end
                end
                CHECK: begin
                    cnt <= '0;
                    if (readback_bad) begin
                        state        <= FAIL_CHK;
                        fail_timeout <= 1'b0;
                    end else begin
                        state     <= DONE;
                        cfg_done  <= 1'b1;
                        flag_stat <= 1'b0;
                        flag_dyn  <= 1'b0;
                    end
                end
                FAIL_CHK: begin
                    cnt <= '0;
                    // A retry replays the word already held on the bridge outputs.
                    if (retry_cnt < 4'(MAX_RETRIES)) begin
                        state     <= LOAD;
                        retry_cnt <= retry_cnt + 4'd1;
                    end else begin
                        state     <= ERR;
                        err_code  <= fail_timeout ? ERR_TIMEOUT : ERR_MISMATCH;
                        cfg_err   <= 1'b1;
                        flag_stat <= 1'b0;
                        flag_dyn  <= 1'b0;
                    end
                end
                DONE, ERR: begin
                    state    <= IDLE;
                    cnt      <= '0;
                    cfg_busy <= 1'b0;
                end
                default: begin
                    state    <= IDLE;
                    cfg_busy <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_asic_config_sequencer.sv
// Scoreboard bench for asic_config_sequencer: directed requests push expected completions,
// a negedge monitor pops and compares them when cfg_done/cfg_err pulses.
`timescale 1ns/1ps
module tb_asic_config_sequencer;

    localparam int unsigned SW = 88;
    localparam int unsigned DW = 16;
    localparam int unsigned TO = 4096;
    localparam int unsigned ST = 16;
    localparam int unsigned MR = 3;

    logic          CLK = 1'b0;
    logic          RST_N;
    logic          req_stat, req_dyn;
    logic [SW-1:0] stat_data_in;
    logic [DW-1:0] dyn_data_in;
    logic          end_config, xor_out_stat, xor_out_dyn;
    logic [SW-1:0] static_conf_ear;
    logic [DW-1:0] dynamic_conf;
    logic          flag_stat, flag_dyn, start_ASIC_config, cfg_busy, cfg_done, cfg_err;
    logic [1:0]    err_code;
    logic [3:0]    retry_cnt;

    asic_config_sequencer #(
        .SIZESRSTAT(SW), .SIZESRDYN(DW), .TIMEOUT_CYCLES(TO),
        .SETTLE_CYCLES(ST), .MAX_RETRIES(MR)
    ) dut (
        .CLK(CLK), .RST_N(RST_N),
        .req_stat(req_stat), .req_dyn(req_dyn),
        .stat_data_in(stat_data_in), .dyn_data_in(dyn_data_in),
        .end_config(end_config), .xor_out_stat(xor_out_stat), .xor_out_dyn(xor_out_dyn),
        .static_conf_ear(static_conf_ear), .dynamic_conf(dynamic_conf),
        .flag_stat(flag_stat), .flag_dyn(flag_dyn),
        .start_ASIC_config(start_ASIC_config),
        .cfg_busy(cfg_busy), .cfg_done(cfg_done), .cfg_err(cfg_err),
        .err_code(err_code), .retry_cnt(retry_cnt)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        bit            is_stat;
        logic [SW-1:0] word;
        bit            ok;
        logic [3:0]    retries;
        logic [1:0]    ec;
        int            starts;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    int   starts_seen = 0, start_cyc = 0, rise_cyc = 0;
    int   overlap = 0, busy_drop = 0;
    logic          snap_stat = 1'b0, snap_dyn = 1'b0;
    logic [SW-1:0] snap_word = '0;

    bit bridge_on;
    int bridge_delay;
    int mism_n;
    int test_id;

    always @(posedge CLK) cyc++;

    task automatic chk(input string name, input logic [SW-1:0] act, input logic [SW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic exp_t mk(bit s, logic [SW-1:0] w, bit ok, logic [3:0] r, logic [1:0] ec, int st);
        exp_t e;
        e.is_stat = s; e.word = w; e.ok = ok; e.retries = r; e.ec = ec; e.starts = st;
        return e;
    endfunction

    // Bridge model: end_config drops on each start and rises bridge_delay cycles later
    // together with the readback result (first mism_n attempts of a test mismatch).
    initial begin : bridge
        int used;
        int seen_test;
        used = 0;
        seen_test = -1;
        end_config = 1'b0;
        xor_out_stat = 1'b0;
        xor_out_dyn = 1'b0;
        forever begin
            @(negedge CLK);
            if (start_ASIC_config) begin
                end_config = 1'b0;
                if (bridge_on) begin
                    repeat (bridge_delay) @(negedge CLK);
                    if (seen_test != test_id) begin
                        used = 0;
                        seen_test = test_id;
                    end
                    xor_out_stat = (used < mism_n);
                    xor_out_dyn  = (used < mism_n);
                    used++;
                    end_config = 1'b1;
                    rise_cyc = cyc;
                end
            end
        end
    end

    // Monitor: snapshot the presented word at each start, score each completion.
    always @(negedge CLK) begin : monitor
        exp_t e;
        if (!RST_N) begin
            starts_seen = 0;
        end else begin
            if (flag_stat && flag_dyn) overlap++;
            if (starts_seen > 0 && !cfg_busy) busy_drop++;
            if (start_ASIC_config) begin
                if (starts_seen == 0) start_cyc = cyc;
                starts_seen++;
                snap_stat = flag_stat;
                snap_dyn  = flag_dyn;
                snap_word = flag_stat ? static_conf_ear : SW'(dynamic_conf);
            end
            if (cfg_done || cfg_err) begin
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_completion: done=%0b err=%0b with nothing expected", cfg_done, cfg_err);
                end else begin
                    e = sb.pop_front();
                    chk("cfg_done", SW'(cfg_done), SW'(e.ok));
                    chk("cfg_err", SW'(cfg_err), SW'(!e.ok));
                    chk("flag_stat_at_start", SW'(snap_stat), SW'(e.is_stat));
                    chk("flag_dyn_at_start", SW'(snap_dyn), SW'(!e.is_stat));
                    chk("word_at_start", snap_word, e.word);
                    chk("word_held", e.is_stat ? static_conf_ear : SW'(dynamic_conf), e.word);
                    chk("retry_cnt", SW'(retry_cnt), SW'(e.retries));
                    chk("err_code", SW'(err_code), SW'(e.ec));
                    chk("start_pulses", SW'(starts_seen), SW'(e.starts));
                    chk("busy_at_completion", SW'(cfg_busy), SW'(1));
                    if (e.ok) chk("done_latency", SW'(cyc - rise_cyc), SW'(ST + 2));
                end
                starts_seen = 0;
            end
        end
    end

    task automatic req_s(input logic [SW-1:0] d, output int rc);
        @(negedge CLK);
        rc = cyc;
        stat_data_in = d;
        req_stat = 1'b1;
        @(negedge CLK);
        req_stat = 1'b0;
    endtask

    task automatic req_d(input logic [DW-1:0] d);
        @(negedge CLK);
        dyn_data_in = d;
        req_dyn = 1'b1;
        @(negedge CLK);
        req_dyn = 1'b0;
    endtask

    task automatic wait_drain(input int max_cyc, input string name);
        int n;
        n = 0;
        while ((sb.size() != 0 || cfg_busy) && n < max_cyc) begin
            @(negedge CLK);
            n++;
        end
        checks++;
        if (sb.size() != 0 || cfg_busy) begin
            errors++;
            $display("FAIL %s_drain: %0d completions still outstanding, busy=%0b after %0d cycles",
                     name, sb.size(), cfg_busy, n);
        end
    endtask

    task automatic check_zero(input string tag);
        chk({tag, "_static_conf_ear"}, static_conf_ear, '0);
        chk({tag, "_dynamic_conf"}, SW'(dynamic_conf), '0);
        chk({tag, "_flag_stat"}, SW'(flag_stat), '0);
        chk({tag, "_flag_dyn"}, SW'(flag_dyn), '0);
        chk({tag, "_start"}, SW'(start_ASIC_config), '0);
        chk({tag, "_busy"}, SW'(cfg_busy), '0);
        chk({tag, "_done"}, SW'(cfg_done), '0);
        chk({tag, "_err"}, SW'(cfg_err), '0);
        chk({tag, "_err_code"}, SW'(err_code), '0);
        chk({tag, "_retry_cnt"}, SW'(retry_cnt), '0);
    endtask

    initial begin : stimulus
        int rc;
        int busy_seen;
        logic [SW-1:0] w_a5, w_3c, w_a, w_b, w_55;
        w_a5 = {11{8'hA5}};
        w_3c = {11{8'h3C}};
        w_a  = {11{8'h11}};
        w_b  = {11{8'h22}};
        w_55 = {11{8'h55}};
        RST_N = 1'b0;
        req_stat = 1'b0;
        req_dyn = 1'b0;
        stat_data_in = '0;
        dyn_data_in = '0;
        bridge_on = 1'b1;
        bridge_delay = 200;
        mism_n = 0;
        test_id = 0;
        repeat (2) @(negedge CLK);
        check_zero("reset");
        @(posedge CLK);
        #2 RST_N = 1'b1;

        // Static pass with start-latency check
        test_id = 1;
        sb.push_back(mk(1'b1, w_a5, 1'b1, 4'd0, 2'b00, 1));
        req_s(w_a5, rc);
        wait_drain(400, "static_pass");
        chk("start_latency", SW'(start_cyc - rc), SW'(3));

        // Simultaneous requests: static first, then dynamic
        test_id = 2;
        bridge_delay = 20;
        sb.push_back(mk(1'b1, w_3c, 1'b1, 4'd0, 2'b00, 1));
        sb.push_back(mk(1'b0, SW'(16'h1234), 1'b1, 4'd0, 2'b00, 1));
        @(negedge CLK);
        stat_data_in = w_3c;
        dyn_data_in = 16'h1234;
        req_stat = 1'b1;
        req_dyn = 1'b1;
        @(negedge CLK);
        req_stat = 1'b0;
        req_dyn = 1'b0;
        wait_drain(300, "simultaneous");

        // Dynamic mismatch on first two checks, then pass
        test_id = 3;
        mism_n = 2;
        sb.push_back(mk(1'b0, SW'(16'hBEEF), 1'b1, 4'd2, 2'b00, 3));
        req_d(16'hBEEF);
        wait_drain(400, "mismatch_retry");

        // Persistent static mismatch
        test_id = 4;
        mism_n = 100;
        sb.push_back(mk(1'b1, w_a, 1'b0, 4'd3, 2'b01, 4));
        req_s(w_a, rc);
        wait_drain(400, "persistent_mismatch");

        // Timeout: bridge never completes
        test_id = 5;
        mism_n = 0;
        bridge_on = 1'b0;
        sb.push_back(mk(1'b0, SW'(16'h0F0F), 1'b0, 4'd3, 2'b10, 4));
        req_d(16'h0F0F);
        wait_drain(4 * (TO + 40), "timeout");
        bridge_on = 1'b1;

        // Re-arm during in-flight static, dynamic overwritten before it starts
        test_id = 6;
        bridge_delay = 60;
        sb.push_back(mk(1'b1, w_a, 1'b1, 4'd0, 2'b00, 1));
        sb.push_back(mk(1'b1, w_b, 1'b1, 4'd0, 2'b00, 1));
        sb.push_back(mk(1'b0, SW'(16'hD00D), 1'b1, 4'd0, 2'b00, 1));
        req_s(w_a, rc);
        repeat (30) @(negedge CLK);
        req_s(w_b, rc);
        req_d(16'hC0DE);
        req_d(16'hD00D);
        wait_drain(600, "rearm_overwrite");

        chk("flags_never_overlap", SW'(overlap), '0);
        chk("busy_never_dropped", SW'(busy_drop), '0);

        // Reset mid-WAIT_END with a dynamic request pending
        test_id = 7;
        bridge_delay = 200;
        sb.push_back(mk(1'b1, w_55, 1'b1, 4'd0, 2'b00, 1));
        req_s(w_55, rc);
        repeat (40) @(negedge CLK);
        req_d(16'h1111);
        @(posedge CLK);
        #2 RST_N = 1'b0;
        #1 check_zero("async_reset");
        sb.delete();
        @(posedge CLK);
        #2 RST_N = 1'b1;
        busy_seen = 0;
        repeat (400) begin
            @(negedge CLK);
            if (cfg_busy) busy_seen++;
        end
        chk("pending_cleared_by_reset", SW'(busy_seen), '0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
